vga_scan_controller: RTL
========================

Name: vga_scan_controller

Overview:
Raster timing generator and pixel output stage for the 640x480 display path. It produces the DrawX/DrawY scan coordinates that the colour mapper, sprite and ROM-lookup logic consume, and takes back the combinational RGB that logic returns. It registers that RGB with blanking applied and drives the VGA DAC pins (RGB, HS, VS, BLANK_N, SYNC_N, pixel clock). It also emits a once-per-frame pulse and a frame counter, which the duck/scope motion logic uses as its frame tick.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, Clk cycles per pixel (>=2)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
in_R  in  8  red from colour mapper for current DrawX/DrawY
in_G  in  8  green from colour mapper
in_B  in  8  blue from colour mapper
DrawX  out  10  current horizontal scan position, 0..H_TOTAL-1
DrawY  out  10  current vertical scan position, 0..V_TOTAL-1
pix_en  out  1  one-Clk strobe, once per pixel period
VGA_CLK  out  1  pixel clock to DAC
VGA_R  out  8  registered red
VGA_G  out  8  registered green
VGA_B  out  8  registered blue
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK_N  out  1  high during active video
VGA_SYNC_N  out  1  tied 0
frame_start  out  1  one-Clk pulse at start of each frame
frame_count  out  8  frames since reset, wraps 255->0

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = 525.
- Clock and reset: all state updates on the rising edge of Clk. Reset is synchronous, active high, and has priority over all other events.
- Reset values:
  - div counter, DrawX, DrawY, frame_count = 0.
  - pix_en = 0, VGA_CLK = 0, frame_start = 0.
  - VGA_R/G/B = 0, VGA_BLANK_N = 0.
  - VGA_HS = 1, VGA_VS = 1.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div == CLK_DIV-1), decoded from the register.
  - VGA_CLK = (div >= CLK_DIV/2).
  - First pix_en occurs CLK_DIV-1 Clk cycles after Reset deasserts.
- Scan counters (advance only on pix_en):
  - DrawX increments; at H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps to 0 after V_TOTAL-1.
  - DrawX and DrawY are held between strobes.
- Frame tick:
  - Fires on the pix_en where (DrawX, DrawY) = (H_TOTAL-1, V_TOTAL-1).
  - The counters wrap to (0,0) on that edge.
  - On the same edge, frame_start is set to 1 for exactly one Clk cycle and frame_count increments (mod 256).
- Output stage (registered on pix_en, from pre-increment DrawX/DrawY and current in_*):
  - vis = DrawX < H_VISIBLE and DrawY < V_VISIBLE.
  - VGA_BLANK_N <= vis.
  - VGA_R/G/B <= vis ? in_* : 0.
  - VGA_HS <= ~(H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC); active for X in 656..751.
  - VGA_VS <= ~(V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC); active for Y in 490..491.
- Latency and alignment:
  - Pins lag DrawX/DrawY by exactly one pixel period. RGB, syncs and blank stay mutually aligned.
  - in_* must settle within one pixel period of a DrawX/DrawY change; the colour mapper is combinational over asynchronous ROMs.
- Pin timing: outputs change at the Clk edge where VGA_CLK falls (div wraps to 0). The DAC samples on the VGA_CLK rise.
- VGA_SYNC_N is constant 0.
- Reset mid-frame: next cycle all state is at reset values. The frame restarts at (0,0) with no frame_start pulse for the aborted frame.

Test Plan:
- Reset release, CLK_DIV=2 -> pix_en high on Clk cycle 1,3,5…; DrawX=1 after first strobe; VGA_HS=VGA_VS=1, RGB=0 during reset.
- Run 800 strobes -> DrawX=0, DrawY=1; frame_count still 0.
- Full frame -> frame_start is a single-cycle pulse every 840000 Clk; frame_count=1, then 2; 256 frames wrap to 0.
- Sync widths -> VGA_HS low for 96 pixel periods (192 Clk), asserted one pixel after DrawX=656; VGA_VS low for 2 lines (1600 pixel periods) starting one pixel after DrawY=490, DrawX=0.
- Blanking -> in_R/G/B = 0xAA/0x55/0xFF constant: pins show AA/55/FF with BLANK_N=1 for X 0..639; 0/0/0 with BLANK_N=0 for X 640..799 and Y 480..524.
- Reset asserted at DrawX=300, DrawY=200 -> one Clk later DrawX=DrawY=0, RGB=0, HS=VS=1, frame_start=0, frame_count=0.

Source files
------------

// File: rtl/vga_scan_controller.sv
// rtl/vga_scan_controller.sv - VGA raster timing generator and registered pixel output stage
module vga_scan_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pix_en,
  output logic       VGA_CLK,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       draw_x_q, draw_x_d;
  logic [9:0]       draw_y_q, draw_y_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic [7:0]       vga_r_q, vga_r_d;
  logic [7:0]       vga_g_q, vga_g_d;
  logic [7:0]       vga_b_q, vga_b_d;
  logic             blank_n_q, blank_n_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;

  logic strobe;
  logic vis;
  logic x_last;
  logic y_last;

  assign strobe = (div_q == DIV_LAST);
  assign x_last = (draw_x_q == X_LAST);
  assign y_last = (draw_y_q == Y_LAST);
  assign vis    = (draw_x_q < X_VIS) && (draw_y_q < Y_VIS);

  // Next-state: divider, scan counters, frame tick and pin stage (pins capture the pre-increment position)
  always_comb begin
    div_d         = strobe ? '0 : div_q + DIV_W'(1);
    draw_x_d      = draw_x_q;
    draw_y_d      = draw_y_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    vga_r_d       = vga_r_q;
    vga_g_d       = vga_g_q;
    vga_b_d       = vga_b_q;
    blank_n_d     = blank_n_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    if (strobe) begin
      if (x_last) begin
        draw_x_d = '0;
        if (y_last) begin
          draw_y_d      = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          draw_y_d = draw_y_q + 10'd1;
        end
      end else begin
        draw_x_d = draw_x_q + 10'd1;
      end
      blank_n_d = vis;
      vga_r_d   = vis ? in_R : 8'd0;
      vga_g_d   = vis ? in_G : 8'd0;
      vga_b_d   = vis ? in_B : 8'd0;
      hs_d      = ~((draw_x_q >= HS_START) && (draw_x_q < HS_END));
      vs_d      = ~((draw_y_q >= VS_START) && (draw_y_q < VS_END));
    end
  end

  // State register with synchronous reset taking priority
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q         <= '0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
      blank_n_q     <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      div_q         <= div_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      blank_n_q     <= blank_n_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign pix_en      = strobe;
  assign VGA_CLK     = (div_q >= DIV_HALF);
  assign VGA_R       = vga_r_q;
  assign VGA_G       = vga_g_q;
  assign VGA_B       = vga_b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule
